xbar_sel_seq: RTL and testbench

XBAR_SEL_SEQ -- requirements
Module: xbar_sel_seq

---
 rtl/mage_pkg.sv | 9 +
 rtl/pea_pkg.sv | 24 ++
 rtl/xbar_sel_cfg_rf.sv | 32 +++
 rtl/xbar_sel_seq.sv | 145 ++++++++++++++
 tb/tb_xbar_sel_seq.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mage_pkg.sv
// Array geometry shared by the PE group and the data-memory streams.
package mage_pkg;

    localparam int N_PE_PER_GROUP         = 4;
    localparam int N_BANKS_PER_STREAM     = 4;
    localparam int LOG_N_PE_PER_GROUP     = $clog2(N_PE_PER_GROUP);
    localparam int LOG_N_BANKS_PER_STREAM = $clog2(N_BANKS_PER_STREAM);

endpackage

// File: rtl/pea_pkg.sv
// Selector-sequencer types: table depth default, FSM states, selector words.
package pea_pkg;

    import mage_pkg::*;

    localparam int N_SEL_CFG_DFLT = 8;
    localparam int PASS_W         = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_e;

    // Element [k] selects the source for destination k.
    typedef logic [N_PE_PER_GROUP-1:0][LOG_N_BANKS_PER_STREAM-1:0] dmem_pea_sel_t;
    typedef logic [N_BANKS_PER_STREAM-1:0][LOG_N_PE_PER_GROUP-1:0] pea_dmem_sel_t;

    typedef struct packed {
        dmem_pea_sel_t dmem_pea;
        pea_dmem_sel_t pea_dmem;
    } sel_entry_t;

endpackage

// File: rtl/xbar_sel_cfg_rf.sv
// Selector table: one synchronous write port, one asynchronous read port.
// Latency: write visible on read port the cycle after we_i; read is combinational.
// Backpressure: none; the caller gates we_i.
module xbar_sel_cfg_rf
    import pea_pkg::*;
#(
    parameter int N_ENTRY = N_SEL_CFG_DFLT
) (
    input  logic                       clk_i,
    input  logic                       rst_i,
    input  logic                       we_i,
    input  logic [$clog2(N_ENTRY)-1:0] waddr_i,
    input  sel_entry_t                 wdata_i,
    input  logic [$clog2(N_ENTRY)-1:0] raddr_i,
    output sel_entry_t                 rdata_o
);

    sel_entry_t mem_q [N_ENTRY];

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            for (int i = 0; i < N_ENTRY; i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/xbar_sel_seq.sv
// Replays the crossbar selector table len entries per pass for iter+1 passes.
// Latency: entry 0 on the outputs one cycle after start is accepted; done_o one cycle after the last entry.
// Backpressure: stall_i (build with XBAR_SEL_SEQ_STALL_EN) freezes index, pass and outputs; otherwise never pauses.
module xbar_sel_seq
    import pea_pkg::*;
#(
    parameter int N_SEL_CFG = N_SEL_CFG_DFLT
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         cfg_we_i,
    input  logic [$clog2(N_SEL_CFG)-1:0] cfg_addr_i,
    input  dmem_pea_sel_t                cfg_dmem_pea_sel_i,
    input  pea_dmem_sel_t                cfg_pea_dmem_sel_i,
    input  logic [$clog2(N_SEL_CFG):0]   cfg_len_i,
    input  logic [PASS_W-1:0]            cfg_iter_i,
    input  logic                         start_i,
`ifdef XBAR_SEL_SEQ_STALL_EN
    input  logic                         stall_i,
`endif
    output dmem_pea_sel_t                sel_dmem_pea_o,
    output pea_dmem_sel_t                sel_pea_dmem_o,
    output logic [$clog2(N_SEL_CFG)-1:0] step_o,
    output logic                         busy_o,
    output logic                         done_o
);

    localparam int AW = $clog2(N_SEL_CFG);
    localparam int LW = AW + 1;

    seq_state_e        state_q, state_d;
    logic [AW-1:0]     idx_q, idx_d;
    logic [PASS_W-1:0] pass_q, pass_d;
    logic [PASS_W-1:0] iter_q, iter_d;
    logic [LW-1:0]     len_q, len_d;
    sel_entry_t        sel_q, sel_d;
    logic [AW-1:0]     step_q, step_d;

    sel_entry_t        rd_entry;
    sel_entry_t        wr_entry;
    logic              rf_we;
    logic              stall;
    logic              last_entry;

`ifdef XBAR_SEL_SEQ_STALL_EN
    assign stall = stall_i;
`else
    assign stall = 1'b0;
`endif

    // The table is frozen while a sequence is replaying it.
    assign rf_we    = cfg_we_i && (state_q != RUN);
    assign wr_entry = '{dmem_pea: cfg_dmem_pea_sel_i, pea_dmem: cfg_pea_dmem_sel_i};

    xbar_sel_cfg_rf #(
        .N_ENTRY (N_SEL_CFG)
    ) u_cfg_rf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .we_i    (rf_we),
        .waddr_i (cfg_addr_i),
        .wdata_i (wr_entry),
        .raddr_i (idx_d),
        .rdata_o (rd_entry)
    );

    assign last_entry = ({1'b0, idx_q} == (len_q - LW'(1)));

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        pass_d  = pass_q;
        iter_d  = iter_q;
        len_d   = len_q;
        unique case (state_q)
            IDLE: begin
                if (start_i && (cfg_len_i != '0)) begin
                    state_d = RUN;
                    idx_d   = '0;
                    pass_d  = '0;
                    iter_d  = cfg_iter_i;
                    len_d   = (cfg_len_i > LW'(N_SEL_CFG)) ? LW'(N_SEL_CFG) : cfg_len_i;
                end
            end
            RUN: begin
                if (!stall) begin
                    if (last_entry) begin
                        // Terminal check first so the pass counter never wraps.
                        if (pass_q == iter_q) begin
                            state_d = DONE;
                        end else begin
                            idx_d  = '0;
                            pass_d = pass_q + PASS_W'(1);
                        end
                    end else begin
                        idx_d = idx_q + AW'(1);
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are registered from the entry that will be current next cycle.
    always_comb begin
        sel_d  = '0;
        step_d = '0;
        if (state_d == RUN) begin
            sel_d  = rd_entry;
            step_d = idx_d;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            idx_q   <= '0;
            pass_q  <= '0;
            iter_q  <= '0;
            len_q   <= '0;
            sel_q   <= '0;
            step_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pass_q  <= pass_d;
            iter_q  <= iter_d;
            len_q   <= len_d;
            sel_q   <= sel_d;
            step_q  <= step_d;
        end
    end

    assign sel_dmem_pea_o = sel_q.dmem_pea;
    assign sel_pea_dmem_o = sel_q.pea_dmem;
    assign step_o         = step_q;
    assign busy_o         = (state_q == RUN);
    assign done_o         = (state_q == DONE);

endmodule

// File: tb/tb_xbar_sel_seq.sv
// Directed bench for xbar_sel_seq with a queue-of-frames reference model.
`timescale 1ns/1ps
module tb_xbar_sel_seq;

    localparam int NS = 8;
    localparam int AW = 3;

    typedef struct {
        logic          busy;
        logic          done;
        logic [AW-1:0] step;
        logic [7:0]    dp;
        logic [7:0]    pd;
    } frame_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_we = 1'b0;
    logic [AW-1:0] cfg_addr = '0;
    logic [7:0]    cfg_dp = '0;
    logic [7:0]    cfg_pd = '0;
    logic [AW:0]   cfg_len = '0;
    logic [15:0]   cfg_iter = '0;
    logic          start = 1'b0;
`ifdef XBAR_SEL_SEQ_STALL_EN
    logic          stall = 1'b0;
`endif
    logic [7:0]    sel_dp;
    logic [7:0]    sel_pd;
    logic [AW-1:0] step;
    logic          busy;
    logic          done;

    frame_t     exp_q[$];
    logic [7:0] tbl_dp[NS];
    logic [7:0] tbl_pd[NS];
    int n_tests  = 0;
    int n_fail   = 0;
    int busy_cnt = 0;
    int done_cnt = 0;

    always #5 clk = ~clk;

    xbar_sel_seq #(.N_SEL_CFG(NS)) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .cfg_we_i           (cfg_we),
        .cfg_addr_i         (cfg_addr),
        .cfg_dmem_pea_sel_i (cfg_dp),
        .cfg_pea_dmem_sel_i (cfg_pd),
        .cfg_len_i          (cfg_len),
        .cfg_iter_i         (cfg_iter),
        .start_i            (start),
`ifdef XBAR_SEL_SEQ_STALL_EN
        .stall_i            (stall),
`endif
        .sel_dmem_pea_o     (sel_dp),
        .sel_pea_dmem_o     (sel_pd),
        .step_o             (step),
        .busy_o             (busy),
        .done_o             (done)
    );

    // Every cycle the DUT must show the next modelled frame, or idle zeros.
    always @(negedge clk) begin : cmp
        frame_t e;
        e = '{busy: 1'b0, done: 1'b0, step: '0, dp: '0, pd: '0};
        if (exp_q.size() != 0) e = exp_q.pop_front();
        n_tests++;
        if ({busy, done, step, sel_dp, sel_pd} !== {e.busy, e.done, e.step, e.dp, e.pd}) begin
            n_fail++;
            $display("FAIL cycle_cmp t=%0t: got busy=%b done=%b step=%0d dp=%h pd=%h, want busy=%b done=%b step=%0d dp=%h pd=%h",
                     $time, busy, done, step, sel_dp, sel_pd, e.busy, e.done, e.step, e.dp, e.pd);
        end
        if (busy === 1'b1) busy_cnt++;
        if (done === 1'b1) done_cnt++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic write_entry(input int a, input logic [7:0] dp, input logic [7:0] pd);
        bit ok;
        ok = (exp_q.size() == 0) || !exp_q[0].busy;
        cfg_we   = 1'b1;
        cfg_addr = AW'(a);
        cfg_dp   = dp;
        cfg_pd   = pd;
        tick();
        cfg_we = 1'b0;
        if (ok) begin
            tbl_dp[a] = dp;
            tbl_pd[a] = pd;
        end
    endtask

    // Expected trace of one accepted run; step sst of pass 0 is shown 1+sn times.
    task automatic push_run(input int len, input int iter, input int sst, input int sn);
        frame_t f;
        int l;
        l = (len > NS) ? NS : len;
        for (int p = 0; p <= iter; p++) begin
            for (int k = 0; k < l; k++) begin
                for (int r = 0; r < ((p == 0 && k == sst) ? 1 + sn : 1); r++) begin
                    f = '{busy: 1'b1, done: 1'b0, step: AW'(k), dp: tbl_dp[k], pd: tbl_pd[k]};
                    exp_q.push_back(f);
                end
            end
        end
        f = '{busy: 1'b0, done: 1'b1, step: '0, dp: '0, pd: '0};
        exp_q.push_back(f);
    endtask

    task automatic start_cmd(input int len, input int iter, input int sst, input int sn);
        bit accept;
        accept   = (exp_q.size() == 0) && (len != 0);
        start    = 1'b1;
        cfg_len  = (AW + 1)'(len);
        cfg_iter = 16'(iter);
        tick();
        start = 1'b0;
        if (accept) push_run(len, iter, sst, sn);
    endtask

    task automatic drain();
        for (int i = 0; i < 300 && exp_q.size() != 0; i++) tick();
        check("drain_timeout", exp_q.size(), 0);
        exp_q.delete();
        tick();
        tick();
    endtask

    task automatic clear_cnt();
        busy_cnt = 0;
        done_cnt = 0;
    endtask

    initial begin
        for (int i = 0; i < NS; i++) begin
            tbl_dp[i] = '0;
            tbl_pd[i] = '0;
        end
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_sel",  {sel_dp, sel_pd}, 0);
        rst = 1'b0;
        tick();

        // Three-entry single pass with hand-packed selector words.
        write_entry(0, 8'hE4, 8'h1B);
        write_entry(1, 8'h39, 8'h6C);
        write_entry(2, 8'h4E, 8'hB1);
        for (int a = 3; a < NS; a++) write_entry(a, 8'(a * 17), 8'(~(a * 17)));
        clear_cnt();
        start_cmd(3, 0, -1, 0);
        check("model_len3_size", exp_q.size(), 4);
        check("model_e1_dp",     exp_q[1].dp, 8'h39);
        check("model_e2_step",   exp_q[2].step, 2);
        check("model_done_last", exp_q[3].done, 1);
        drain();
        check("len3_busy_cycles", busy_cnt, 3);
        check("len3_done_pulses", done_cnt, 1);

        // Two entries, three passes.
        clear_cnt();
        start_cmd(2, 2, -1, 0);
        drain();
        check("len2_iter2_busy", busy_cnt, 6);
        check("len2_iter2_done", done_cnt, 1);

        // Zero length is ignored; oversize length clamps to the table depth.
        clear_cnt();
        start_cmd(0, 0, -1, 0);
        repeat (4) tick();
        check("len0_busy", busy_cnt, 0);
        check("len0_done", done_cnt, 0);
        clear_cnt();
        start_cmd(15, 0, -1, 0);
        check("model_clamp_size", exp_q.size(), 9);
        drain();
        check("clamp_busy", busy_cnt, 8);

        // Writes and starts during RUN have no effect.
        clear_cnt();
        start_cmd(3, 1, -1, 0);
        write_entry(1, 8'hFF, 8'h00);
        start_cmd(2, 0, -1, 0);
        drain();
        check("run_ignore_busy", busy_cnt, 6);
        clear_cnt();
        start_cmd(2, 0, -1, 0);
        tick();
        check("replay_old_e1", sel_dp, 8'h39);
        drain();

`ifdef XBAR_SEL_SEQ_STALL_EN
        // Stall for three cycles while entry 1 is driven.
        clear_cnt();
        start_cmd(3, 0, 1, 3);
        tick();
        stall = 1'b1;
        repeat (3) tick();
        stall = 1'b0;
        drain();
        check("stall_busy", busy_cnt, 6);
        check("stall_done", done_cnt, 1);
`endif

        // Reset mid-run at step 1: outputs clear at once, no done, table cleared.
        clear_cnt();
        start_cmd(3, 0, -1, 0);
        tick();
        check("pre_rst_step", step, 1);
        rst = 1'b1;
        exp_q.delete();
        for (int i = 0; i < NS; i++) begin
            tbl_dp[i] = '0;
            tbl_pd[i] = '0;
        end
        #1;
        check("rst_now_busy", busy, 0);
        check("rst_now_step", step, 0);
        check("rst_now_sel",  {sel_dp, sel_pd}, 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("rst_no_done", done_cnt, 0);
        clear_cnt();
        start_cmd(3, 0, -1, 0);
        drain();
        check("post_rst_busy", busy_cnt, 3);
        check("post_rst_done", done_cnt, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
